// File: rtl/mux_sel_arbiter.sv
// Round-robin owner of the shared 4:1 select mux: grants one requester at a time,
// drives the registered select pair, and releases on done, request drop or hold timeout.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       sel_x,
    output logic       sel_y,
    output logic       busy
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state;
    logic [1:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        win;
    logic              win_vld;
    logic [1:0]        idx;
    logic              release_c;

    // Scan from the farthest offset down so the offset closest to ptr wins.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    assign release_c = done | ~|(req & gnt) | (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            sel_x    <= 1'b0;
            sel_y    <= 1'b0;
            busy     <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state          <= GRANT;
                        gnt            <= 4'b0001 << win;
                        {sel_x, sel_y} <= win;
                        busy           <= 1'b1;
                        hold_cnt       <= '0;
                        ptr            <= win + 2'd1;
                    end
                end
                GRANT: begin
                    // Select lines are left alone on release so the mux output holds steady.
                    if (release_c) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Scoreboard bench for mux_sel_arbiter: a behavioural model pushes expected outputs
// as each cycle is driven; they are popped and compared after the edge.
module tb_mux_sel_arbiter;
    localparam int MAX_HOLD = 15;
    localparam int HOLD_W   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       done = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] gnt;
    logic       sel_x, sel_y, busy;

    mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .sel_x(sel_x), .sel_y(sel_y), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    endtask

    // model state mirrors what the DUT should hold after the last edge
    logic [3:0] m_gnt = '0;
    logic [1:0] m_sel = '0;
    logic       m_busy = 1'b0;
    int         m_ptr = 0;
    int         m_cnt = 0;
    logic [6:0] exp_q[$];

    task automatic model_step(input logic r, input logic [3:0] q, input logic d);
        int w;
        int i;
        w = -1;
        if (r) begin
            m_gnt = '0; m_sel = '0; m_busy = 1'b0; m_ptr = 0; m_cnt = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                i = (m_ptr + k) % 4;
                if (w < 0 && q[i]) w = i;
            end
            if (w >= 0) begin
                m_gnt  = 4'b0001 << w;
                m_sel  = w[1:0];
                m_busy = 1'b1;
                m_cnt  = 0;
                m_ptr  = (w + 1) % 4;
            end
        end else begin
            if (d || ((q & m_gnt) == 4'b0000) || m_cnt == MAX_HOLD - 1) begin
                m_gnt  = '0;
                m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic cyc(input logic r, input logic [3:0] q, input logic d);
        logic [6:0] e;
        @(negedge clk);
        rst = r; req = q; done = d;
        model_step(r, q, d);
        exp_q.push_back({m_gnt, m_sel, m_busy});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("gnt", {28'd0, gnt}, {28'd0, e[6:3]});
            chk("sel", {30'd0, sel_x, sel_y}, {30'd0, e[2:1]});
            chk("busy", {31'd0, busy}, {31'd0, e[0]});
            chk("onehot0", {31'd0, ($countones(gnt) <= 1)}, 32'd1);
            chk("busy_or", {31'd0, busy}, {31'd0, |gnt});
            if (busy) chk("sel_idx", {30'd0, sel_x, sel_y}, {30'd0, idx_of(gnt)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq[$];
        logic [3:0] hist[$];
        logic [3:0] prev;
        logic       d;
        int         s, e;

        // reset then idle
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 4'b0000, 1'b0);

        // single request with done three cycles after the grant
        cyc(1'b0, 4'b0100, 1'b0);
        chk("t2_gnt", {28'd0, gnt}, 32'h4);
        chk("t2_sel", {30'd0, sel_x, sel_y}, 32'h2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100, 1'b0);
        cyc(1'b0, 4'b0100, 1'b1);
        chk("t2_rel", {28'd0, gnt}, 32'd0);
        chk("t2_sel_hold", {30'd0, sel_x, sel_y}, 32'h2);
        cyc(1'b0, 4'b0000, 1'b0);

        // rotation with all requesting, done on each grant's second cycle
        cyc(1'b1, 4'b0000, 1'b0);
        prev = '0;
        for (int i = 0; i < 40 && seq.size() < 5; i++) begin
            d = m_busy && (m_cnt == 1);
            cyc(1'b0, 4'b1111, d);
            if (gnt != 4'b0000 && prev == 4'b0000) seq.push_back(gnt);
            prev = gnt;
        end
        chk("rot_cnt", seq.size(), 32'd5);
        if (seq.size() == 5) begin
            chk("rot0", {28'd0, seq[0]}, 32'h1);
            chk("rot1", {28'd0, seq[1]}, 32'h2);
            chk("rot2", {28'd0, seq[2]}, 32'h4);
            chk("rot3", {28'd0, seq[3]}, 32'h8);
            chk("rot4", {28'd0, seq[4]}, 32'h1);
        end
        cyc(1'b0, 4'b0000, 1'b0);

        // hold timeout with a persistent requester
        cyc(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 22; i++) begin
            cyc(1'b0, 4'b0010, 1'b0);
            hist.push_back(gnt);
        end
        s = 0;
        while (s < hist.size() && hist[s] == 4'b0000) s++;
        e = s;
        while (e < hist.size() && hist[e] == 4'b0010) e++;
        chk("to_len", e - s, MAX_HOLD);
        if (e + 1 < hist.size()) begin
            chk("to_gap", {28'd0, hist[e]}, 32'd0);
            chk("to_regnt", {28'd0, hist[e+1]}, 32'h2);
        end else begin
            chk("to_range", 32'd0, 32'd1);
        end
        cyc(1'b0, 4'b0000, 1'b0);

        // pointer advances past requester 0
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0);
        chk("t5_first", {28'd0, gnt}, 32'h1);
        cyc(1'b0, 4'b0001, 1'b1);
        cyc(1'b0, 4'b1001, 1'b0);
        chk("t5_win", {28'd0, gnt}, 32'h8);

        // reset during a grant
        cyc(1'b0, 4'b1000, 1'b0);
        cyc(1'b1, 4'b1000, 1'b0);
        chk("t6_gnt", {28'd0, gnt}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_sel", {30'd0, sel_x, sel_y}, 32'd0);
        cyc(1'b0, 4'b1001, 1'b0);
        chk("t6_prio", {28'd0, gnt}, 32'h1);
        cyc(1'b0, 4'b0000, 1'b0);
        cyc(1'b0, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
